lcd_bus_scheduler: RTL and testbench

//   Sole owner of the character-LCD bus (DATA/RS/RW/EN/RST). Runs the power-on init sequence,

---
 rtl/lcd_bus_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_lcd_bus_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: sole owner of the character-LCD bus.
// Runs the LCD power-on init, then round-robins byte writes from A/B.
// Ports:
//   clk, reset (async, active-low)
//   a_valid/a_rs/a_data/a_ready : requester A (command/text)
//   b_valid/b_rs/b_data/b_ready : requester B (frame refresh)
//   lcd_data/lcd_rs/lcd_rw/lcd_en/lcd_rst : LCD pins
//   init_done : init finished; busy : not idle or not initialised
module lcd_bus_scheduler #(
    parameter int SETUP_CYC     = 1,
    parameter int EN_HIGH_CYC   = 4,
    parameter int HOLD_CYC      = 2,
    parameter int GAP_CYC       = 40,
    parameter int LONG_GAP_CYC  = 1600,
    parameter int INIT_WAIT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    input  logic       a_rs,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_rs,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_rst,
    output logic       init_done,
    output logic       busy
);

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    localparam int MAXC = max2(max2(INIT_WAIT_CYC, LONG_GAP_CYC),
                               max2(max2(SETUP_CYC, EN_HIGH_CYC),
                                    max2(HOLD_CYC, GAP_CYC)));
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] WAIT_LAST  = CW'(INIT_WAIT_CYC - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] LGAP_LAST  = CW'(LONG_GAP_CYC - 1);

    localparam logic [2:0] RST_WAIT   = 3'd0;
    localparam logic [2:0] INIT_ISSUE = 3'd1;
    localparam logic [2:0] IDLE       = 3'd2;
    localparam logic [2:0] SETUP      = 3'd3;
    localparam logic [2:0] PULSE      = 3'd4;
    localparam logic [2:0] HOLD       = 3'd5;
    localparam logic [2:0] GAP        = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic          init_done_q, init_done_d;
    logic          lcd_rst_q, lcd_rst_d;
    logic          lcd_en_q, lcd_en_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic [7:0]    lcd_data_q, lcd_data_d;
    logic          last_b_q, last_b_d;

    logic          idle;
    logic          grant_a;
    logic          grant_b;
    logic          long_gap;
    logic          phase_end;
    logic [CW-1:0] phase_last;
    logic [7:0]    init_byte;

    always_comb begin
        init_byte = 8'h01;
        case (init_idx_q)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    end

    // Clear and home need the slow controller path.
    assign long_gap = !lcd_rs_q &&
                      (lcd_data_q == 8'h01 || lcd_data_q == 8'h02);

    always_comb begin
        phase_last = '0;
        case (state_q)
            RST_WAIT: phase_last = WAIT_LAST;
            SETUP:    phase_last = SETUP_LAST;
            PULSE:    phase_last = EN_LAST;
            HOLD:     phase_last = HOLD_LAST;
            GAP:      phase_last = long_gap ? LGAP_LAST : GAP_LAST;
            default:  phase_last = '0;
        endcase
    end

    assign phase_end = (cnt_q == phase_last);

    // On contention the requester not served last wins.
    assign idle    = (state_q == IDLE) && init_done_q;
    assign grant_a = idle && a_valid && (!b_valid || last_b_q);
    assign grant_b = idle && b_valid && (!a_valid || !last_b_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        lcd_rst_d   = lcd_rst_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        last_b_d    = last_b_q;
        unique case (state_q)
            RST_WAIT: begin
                if (phase_end) begin
                    lcd_rst_d = 1'b0;
                    state_d   = INIT_ISSUE;
                    cnt_d     = '0;
                end
            end
            INIT_ISSUE: begin
                lcd_data_d = init_byte;
                lcd_rs_d   = 1'b0;
                state_d    = SETUP;
                cnt_d      = '0;
            end
            IDLE: begin
                cnt_d = '0;
                if (grant_a) begin
                    lcd_data_d = a_data;
                    lcd_rs_d   = a_rs;
                    last_b_d   = 1'b0;
                    state_d    = SETUP;
                end else if (grant_b) begin
                    lcd_data_d = b_data;
                    lcd_rs_d   = b_rs;
                    last_b_d   = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (phase_end) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (init_done_q) begin
                        state_d = IDLE;
                    end else if (init_idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        state_d    = INIT_ISSUE;
                    end
                end
            end
            default: begin
                state_d = RST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // EN is registered from the next state so it is glitch-free.
    assign lcd_en_d = (state_d == PULSE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RST_WAIT;
            cnt_q       <= '0;
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
            lcd_rst_q   <= 1'b1;
            lcd_en_q    <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            last_b_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            lcd_rst_q   <= lcd_rst_d;
            lcd_en_q    <= lcd_en_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
            last_b_q    <= last_b_d;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign lcd_data  = lcd_data_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = lcd_en_q;
    assign lcd_rst   = lcd_rst_q;
    assign init_done = init_done_q;
    assign busy      = !idle;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler: randomized scoreboard bench for lcd_bus_scheduler.
// Reference model predicts grants/timing; monitor checks LCD writes.
module tb_lcd_bus_scheduler;

    localparam int SETUP = 1;
    localparam int ENH   = 2;
    localparam int HOLD  = 1;
    localparam int GAP   = 3;
    localparam int LGAP  = 10;
    localparam int IWAIT = 8;
    localparam int BIG   = 1 << 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_valid = 1'b0;
    logic       a_rs = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_rs = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       a_ready, b_ready;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_rst;
    logic       init_done, busy;

    lcd_bus_scheduler #(
        .SETUP_CYC    (SETUP),
        .EN_HIGH_CYC  (ENH),
        .HOLD_CYC     (HOLD),
        .GAP_CYC      (GAP),
        .LONG_GAP_CYC (LGAP),
        .INIT_WAIT_CYC(IWAIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_rs     (a_rs),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_rs     (b_rs),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_rst  (lcd_rst),
        .init_done(init_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         acc;
    } wr_t;

    wr_t exp_q[$];
    int  init_free = BIG;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d",
                     name, act, req, cyc);
        end
    endtask

    function automatic int gap_of(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? LGAP : GAP;
    endfunction

    // Reference model: write occupancy timeline and round-robin grant.
    bit last_b;
    int free_cyc;
    always @(negedge clk) begin : model
        bit idle_m, pa, pb, ini;
        wr_t w;
        if (!reset) begin
            last_b   = 1'b1;
            free_cyc = 0;
            exp_q.delete();
            w.rs = 1'b0; w.acc = -1;
            w.data = 8'h38; exp_q.push_back(w);
            w.data = 8'h0C; exp_q.push_back(w);
            w.data = 8'h06; exp_q.push_back(w);
            w.data = 8'h01; exp_q.push_back(w);
        end else begin
            ini    = (cyc >= init_free);
            idle_m = ini && (cyc >= free_cyc);
            pa = idle_m && a_valid && (!b_valid || last_b);
            pb = idle_m && b_valid && (!a_valid || !last_b);
            check("a_ready", a_ready, pa);
            check("b_ready", b_ready, pb);
            check("init_done", init_done, ini);
            check("busy", busy, !idle_m);
            if (pa) begin
                w.rs = a_rs; w.data = a_data; w.acc = cyc;
                exp_q.push_back(w);
                last_b = 1'b0;
                free_cyc = cyc + SETUP + ENH + HOLD + gap_of(a_rs, a_data) + 1;
            end else if (pb) begin
                w.rs = b_rs; w.data = b_data; w.acc = cyc;
                exp_q.push_back(w);
                last_b = 1'b1;
                free_cyc = cyc + SETUP + ENH + HOLD + gap_of(b_rs, b_data) + 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every EN rising edge.
    logic       en_p, rst_p, rs_p;
    logic [7:0] d_p;
    int         en_len, rst_cnt, nfall;
    bit         stab_bad;
    always @(negedge clk) begin : mon
        wr_t w;
        if (!reset) begin
            en_p = 1'b0; rst_p = 1'b1; rst_cnt = 0; nfall = 0;
            en_len = 0; stab_bad = 1'b0; init_free = BIG;
            d_p = lcd_data; rs_p = lcd_rs;
        end else begin
            if (lcd_rst) rst_cnt++;
            if (!lcd_rst && rst_p) check("lcd_rst_len", 32'(rst_cnt), IWAIT);
            if (lcd_en && !en_p) begin
                stab_bad = 1'b0;
                en_len = 0;
                check("lcd_rw", lcd_rw, 0);
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write actual=%0h required=none",
                             lcd_data);
                end else begin
                    w = exp_q.pop_front();
                    check("lcd_data", lcd_data, w.data);
                    check("lcd_rs", lcd_rs, w.rs);
                    if (w.acc >= 0)
                        check("en_delay", 32'(cyc - w.acc), SETUP + 1);
                end
            end
            if ((lcd_en || en_p) && (lcd_data !== d_p || lcd_rs !== rs_p))
                stab_bad = 1'b1;
            if (lcd_en) en_len++;
            if (!lcd_en && en_p) begin
                check("en_width", 32'(en_len), ENH);
                check("bus_stable", stab_bad, 0);
                nfall++;
                if (nfall == 4) init_free = cyc + HOLD + LGAP;
            end
            en_p = lcd_en; rst_p = lcd_rst; d_p = lcd_data; rs_p = lcd_rs;
        end
    end

    task automatic tick(output bit ah, output bit bh);
        @(negedge clk);
        ah = a_valid && a_ready;
        bh = b_valid && b_ready;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = $urandom_range(3);
        if (r == 0) return 8'h01;
        if (r == 1) return 8'h02;
        return 8'($urandom);
    endfunction

    task automatic wait_init();
        bit ah, bh;
        for (int i = 0; i < 200; i++) begin
            tick(ah, bh);
            if (init_done) break;
        end
        check("init_wait", init_done, 1);
    endtask

    task automatic send(input bit to_b, input logic rs, input logic [7:0] d);
        bit ah, bh, got;
        got = 1'b0;
        if (to_b) begin b_valid = 1; b_rs = rs; b_data = d; end
        else      begin a_valid = 1; a_rs = rs; a_data = d; end
        for (int i = 0; i < 100; i++) begin
            tick(ah, bh);
            if ((to_b && bh) || (!to_b && ah)) begin
                got = 1'b1;
                break;
            end
        end
        if (to_b) b_valid = 0; else a_valid = 0;
        check("send_hs", got, 1);
    endtask

    task automatic rand_run(input int n);
        bit ah, bh;
        repeat (n) begin
            tick(ah, bh);
            if (a_valid && !ah) begin
                if ($urandom_range(9) == 0) a_valid = 0;
            end else begin
                a_valid = ($urandom_range(2) == 0);
                a_rs    = 1'($urandom_range(1));
                a_data  = pick();
            end
            if (b_valid && !bh) begin
                if ($urandom_range(9) == 0) b_valid = 0;
            end else begin
                b_valid = ($urandom_range(2) == 0);
                b_rs    = 1'($urandom_range(1));
                b_data  = pick();
            end
        end
        a_valid = 0;
        b_valid = 0;
    endtask

    initial begin
        bit ah, bh;
        int nhs;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        wait_init();

        send(0, 1'b1, 8'h52);
        repeat (12) tick(ah, bh);

        a_valid = 1; a_rs = 1; a_data = 8'($urandom);
        b_valid = 1; b_rs = 1; b_data = 8'($urandom);
        nhs = 0;
        for (int i = 0; i < 100 && nhs < 8; i++) begin
            tick(ah, bh);
            if (ah) begin a_data = 8'($urandom); nhs++; end
            if (bh) begin b_data = 8'($urandom); nhs++; end
        end
        a_valid = 0;
        b_valid = 0;
        check("alt_count", 32'(nhs), 8);

        send(1, 1'b0, 8'h01);
        send(1, 1'b0, 8'h80);
        send(0, 1'b0, 8'h02);
        send(1, 1'b1, 8'h01);
        repeat (15) tick(ah, bh);

        rand_run(400);
        repeat (20) tick(ah, bh);

        send(0, 1'b1, 8'h41);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_en) break;
        end
        check("pulse_seen", lcd_en, 1);
        #2 reset = 0;
        #1;
        check("rst_en_low", lcd_en, 0);
        check("rst_lcd_rst", lcd_rst, 1);
        check("rst_data", lcd_data, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1;
        wait_init();

        rand_run(300);
        repeat (40) tick(ah, bh);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
